// File: rtl/cpu_ifetch_q.sv
// Instruction prefetch queue: credit-based fetch, in-order acks, flush/drop on redirect.
// Optional perf counters (perf_starve, perf_flush) are enabled with CPU_IFETCH_PERF_EN.
module cpu_ifetch_q #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'hFFFF0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        p2_bubble,
  input  logic        p4_jump_taken,
  input  logic [31:0] p4_jump_addr,
  output logic        cpui_request,
  output logic [31:0] cpui_addr,
  input  logic [31:0] cpui_rdata,
  input  logic        cpui_ack,
  output logic [31:0] p2_instr,
  output logic [31:0] p2_pc,
  output logic        p2_instr_valid,
  output logic [31:0] p3_pc,
  output logic [31:0] p4_pc,
  output logic [31:0] p4_instr
`ifdef CPU_IFETCH_PERF_EN
  ,
  output logic [31:0] perf_starve,
  output logic [31:0] perf_flush
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [31:0]   fetch_pc, ack_pc, last_addr, jump_pc;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, drop, outstanding_nxt;
  logic [CW:0]   credit_used;
  logic          ack_valid, ack_drop, push, pop;
  logic [31:0]   p3_pc_q, p3_instr, p4_pc_q, p4_instr_q;

  always_comb begin
    credit_used     = {1'b0, count} + {1'b0, outstanding};
    cpui_request    = !reset && !p4_jump_taken && (credit_used < (CW+1)'(DEPTH));
    cpui_addr       = reset ? RESET_ADDR : (cpui_request ? fetch_pc : last_addr);
    // Acks with nothing outstanding are strays (e.g. from before a reset).
    ack_valid       = cpui_ack && (outstanding != '0);
    ack_drop        = ack_valid && ((drop != '0) || p4_jump_taken);
    push            = ack_valid && !ack_drop;
    outstanding_nxt = outstanding + CW'(cpui_request) - CW'(ack_valid);
    jump_pc         = p4_jump_addr & ~32'h3;
    p2_instr_valid  = !reset && (count != '0);
    p2_pc           = p2_instr_valid ? q_pc[rd_ptr]    : 32'h0;
    p2_instr        = p2_instr_valid ? q_instr[rd_ptr] : 32'h0;
    pop             = p2_instr_valid && !stall && !p2_bubble && !p4_jump_taken;
    p3_pc           = reset ? 32'h0 : p3_pc_q;
    p4_pc           = reset ? 32'h0 : p4_pc_q;
    p4_instr        = reset ? 32'h0 : p4_instr_q;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr]    <= ack_pc;
      q_instr[wr_ptr] <= cpui_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_ADDR;
      ack_pc      <= RESET_ADDR;
      last_addr   <= RESET_ADDR;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (cpui_request) begin
        fetch_pc  <= fetch_pc + 32'd4;
        last_addr <= fetch_pc;
      end
      if (p4_jump_taken) begin
        // Every request still live after this cycle belongs to the old stream.
        fetch_pc <= jump_pc;
        ack_pc   <= jump_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop     <= outstanding_nxt;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
          ack_pc <= ack_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (ack_drop) drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p3_pc_q    <= 32'h0;
      p3_instr   <= 32'h0;
      p4_pc_q    <= 32'h0;
      p4_instr_q <= 32'h0;
    end else begin
      if (!stall) begin
        p3_pc_q    <= p2_pc;
        p3_instr   <= p2_instr;
        p4_pc_q    <= p3_pc_q;
        p4_instr_q <= p3_instr;
      end
      if (p4_jump_taken) begin
        p3_pc_q  <= 32'h0;
        p3_instr <= 32'h0;
      end
    end
  end

`ifdef CPU_IFETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_starve <= 32'h0;
      perf_flush  <= 32'h0;
    end else begin
      if (!p2_instr_valid && !stall && (perf_starve != 32'hFFFFFFFF))
        perf_starve <= perf_starve + 32'd1;
      if (ack_drop && (perf_flush != 32'hFFFFFFFF))
        perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_ifetch_q.sv
// Scoreboard bench for cpu_ifetch_q: transaction-level fetch model with epoch-tagged requests.
// Perf counter checks are compiled in when CPU_IFETCH_PERF_EN is defined.
module tb_cpu_ifetch_q;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RST_A = 32'hFFFF0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        p2_bubble = 1'b0;
  logic        p4_jump_taken = 1'b0;
  logic [31:0] p4_jump_addr = 32'h0;
  logic [31:0] cpui_rdata = 32'h0;
  logic        cpui_ack = 1'b0;
  logic        cpui_request;
  logic [31:0] cpui_addr, p2_instr, p2_pc, p3_pc, p4_pc, p4_instr;
  logic        p2_instr_valid;
`ifdef CPU_IFETCH_PERF_EN
  logic [31:0] perf_starve, perf_flush;
`endif

  always #5 clock = ~clock;

  cpu_ifetch_q #(.DEPTH(DEPTH), .RESET_ADDR(RST_A)) dut (
    .clock(clock), .reset(reset), .stall(stall), .p2_bubble(p2_bubble),
    .p4_jump_taken(p4_jump_taken), .p4_jump_addr(p4_jump_addr),
    .cpui_request(cpui_request), .cpui_addr(cpui_addr),
    .cpui_rdata(cpui_rdata), .cpui_ack(cpui_ack),
    .p2_instr(p2_instr), .p2_pc(p2_pc), .p2_instr_valid(p2_instr_valid),
    .p3_pc(p3_pc), .p4_pc(p4_pc), .p4_instr(p4_instr)
`ifdef CPU_IFETCH_PERF_EN
    , .perf_starve(perf_starve), .perf_flush(perf_flush)
`endif
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] epoch; } pend_t;
  typedef struct packed { logic [31:0] pc;   logic [31:0] instr; } ent_t;

  pend_t       pend_q[$];   // requests the bus has not answered yet
  ent_t        exp_q[$];    // instructions the front end should present, in order
  logic [31:0] epoch = 32'h0;
  logic [31:0] m_fetch = RST_A, m_last = RST_A;
  logic [31:0] m_p3pc = 0, m_p3instr = 0, m_p4pc = 0, m_p4instr = 0;
  logic [31:0] head_pc = 0, head_instr = 0;
  bit          mon_popped = 0, mon_valid = 0;
  int          m_flush = 0, m_starve = 0;
  int          checks = 0, errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares the queue head and pipe registers, pops when the decoder consumes.
  always @(negedge clock) begin
    ent_t h;
    #1;
    mon_popped = 0;
    if (reset) begin
      mon_valid = 0; head_pc = 0; head_instr = 0;
      chk("rst_p2_valid", {31'h0, p2_instr_valid}, 32'h0);
      chk("rst_p2_pc", p2_pc, 32'h0);
      chk("rst_p2_instr", p2_instr, 32'h0);
      chk("rst_p3_pc", p3_pc, 32'h0);
      chk("rst_p4_pc", p4_pc, 32'h0);
      chk("rst_p4_instr", p4_instr, 32'h0);
      chk("rst_request", {31'h0, cpui_request}, 32'h0);
      chk("rst_addr", cpui_addr, RST_A);
    end else begin
      mon_valid = (exp_q.size() > 0);
      h = mon_valid ? exp_q[0] : '0;
      head_pc = h.pc; head_instr = h.instr;
      chk("p2_valid", {31'h0, p2_instr_valid}, {31'h0, mon_valid});
      chk("p2_pc", p2_pc, h.pc);
      chk("p2_instr", p2_instr, h.instr);
      chk("p3_pc", p3_pc, m_p3pc);
      chk("p4_pc", p4_pc, m_p4pc);
      chk("p4_instr", p4_instr, m_p4instr);
      if (mon_valid && !stall && !p2_bubble && !p4_jump_taken) begin
        void'(exp_q.pop_front());
        mon_popped = 1;
      end
    end
  end

  // One clock of stimulus plus the reference model's view of that clock.
  task automatic cycle(input bit rst, input bit st, input bit bub, input bit jmp,
                       input logic [31:0] ja, input bit ack);
    bit    exp_req;
    int    occ;
    pend_t p;
    @(negedge clock);
    reset = rst; stall = st; p2_bubble = bub; p4_jump_taken = jmp;
    p4_jump_addr = ja; cpui_ack = ack;
    cpui_rdata = (pend_q.size() > 0) ? mem_word(pend_q[0].addr) : $urandom;
    #2;
    if (rst) begin
      exp_q.delete(); pend_q.delete();
      epoch++;
      m_fetch = RST_A; m_last = RST_A;
      m_p3pc = 0; m_p3instr = 0; m_p4pc = 0; m_p4instr = 0;
      m_flush = 0; m_starve = 0;
      return;
    end
    occ = exp_q.size() + int'(mon_popped);
    exp_req = !jmp && (occ + pend_q.size() < DEPTH);
    chk("request", {31'h0, cpui_request}, {31'h0, exp_req});
    chk("req_addr", cpui_addr, exp_req ? m_fetch : m_last);
    if (!mon_valid && !st) m_starve++;
    if (ack && pend_q.size() > 0) begin
      p = pend_q.pop_front();
      if (p.epoch == epoch && !jmp) exp_q.push_back({p.addr, mem_word(p.addr)});
      else m_flush++;
    end
    if (exp_req) begin
      pend_q.push_back({m_fetch, epoch});
      m_last = m_fetch;
      m_fetch = m_fetch + 32'd4;
    end
    if (jmp) begin
      exp_q.delete();
      epoch++;
      m_fetch = {ja[31:2], 2'b00};
    end
    if (!st) begin
      m_p4pc = m_p3pc; m_p4instr = m_p3instr;
      m_p3pc = head_pc; m_p3instr = head_instr;
    end
    if (jmp) begin m_p3pc = 0; m_p3instr = 0; end
  endtask

  initial begin
    repeat (3) cycle(1, 0, 0, 0, 0, 0);
    // Back-to-back fetch from reset with single-cycle acks.
    repeat (10) cycle(0, 0, 0, 0, 0, 1);
    // Stall with acks streaming: credits cap the queue at DEPTH.
    repeat (10) cycle(0, 1, 0, 0, 0, 1);
    repeat (6)  cycle(0, 0, 0, 0, 0, 1);
    // Redirect to a misaligned target with two requests in flight.
    repeat (2) cycle(1, 0, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h0000_1003, 0);
    repeat (8) cycle(0, 0, 0, 0, 0, 1);
    // Decoder bubble over a full queue, then release.
    repeat (8) cycle(0, 0, 1, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 0, 0, 0);
    // Reset mid-transfer with stray acks during and just after reset.
    repeat (3) cycle(0, 1, 0, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0, 0, 1);
    // Ack landing in the same cycle as a redirect.
    repeat (2) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h0000_2000, 1);
    repeat (8) cycle(0, 0, 0, 0, 0, 1);
    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 32) == 0,
            $urandom, $urandom_range(0, 9) < 6);
    repeat (20) cycle(0, 0, 0, 0, 0, 1);
`ifdef CPU_IFETCH_PERF_EN
    #1;
    chk("perf_flush", perf_flush, m_flush);
    chk("perf_starve", perf_starve, m_starve);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
